vga_mem_arbiter: RTL and testbench

- Shares the single port of the main block RAM between two requesters.
- The VGA tile/picture-number fetch path is timing-critical and has priority.
- The CPU load/store path is serviced in idle slots, with a starvation guard.
- The block sits between the memory-access logic, the CPU memory interface and the block RAM port, and owns all RAM port control signals.

---
 rtl/vga_mem_pkg.sv | 23 ++
 rtl/vga_mem_starve_cnt.sv | 31 +++
 rtl/vga_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_vga_mem_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// Shared types for the VGA/CPU block-RAM arbiter.
// Owner tags travel with each access through the two-stage response pipeline.
package vga_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = 255;

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_VGA  = 2'd1,
        OWNER_CPU  = 2'd2
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   we;
    } tag_t;

    localparam tag_t TAG_IDLE = '{owner: OWNER_IDLE, we: 1'b0};

endpackage

// File: rtl/vga_mem_starve_cnt.sv
// Counts consecutive cycles a pending CPU request loses arbitration and
// raises o_force once the loss count reaches STARVE_LIMIT.
module vga_mem_starve_cnt
    import vga_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cpu_req,
    input  logic i_cpu_gnt,
    output logic o_force
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_cpu_req && !i_cpu_gnt) begin
            if (r_cnt != CNT_W'(CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_force = i_cpu_req && (r_cnt >= CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port block-RAM arbiter: VGA fetch has priority, CPU fills idle slots.
// Responses return two clocks after the accept edge, in grant order.
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic              w_force;
    logic              w_cpu_gnt;
    logic              w_vga_gnt;
    logic              w_any_gnt;
    tag_t              w_tag;
    logic [ADDR_W-1:0] w_addr;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    tag_t              r_tag1;
    tag_t              r_tag2;
    logic [DATA_W-1:0] r_vga_rdata;
    logic              r_vga_valid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_ack;

    vga_mem_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_cpu_req (cpu_req),
        .i_cpu_gnt (w_cpu_gnt),
        .o_force   (w_force)
    );

    // Grants are gated by reset so nothing is accepted while rst is high.
    assign w_cpu_gnt = !rst && cpu_req && (!vga_req || w_force);
    assign w_vga_gnt = !rst && vga_req && !w_cpu_gnt;
    assign w_any_gnt = w_cpu_gnt || w_vga_gnt;
    assign w_addr    = w_cpu_gnt ? cpu_addr : vga_addr;

    always_comb begin
        w_tag = TAG_IDLE;
        unique case (1'b1)
            w_cpu_gnt: w_tag = '{owner: OWNER_CPU, we: cpu_we};
            w_vga_gnt: w_tag = '{owner: OWNER_VGA, we: 1'b0};
            default:   w_tag = TAG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_tag1     <= TAG_IDLE;
            r_tag2     <= TAG_IDLE;
        end else begin
            r_tag1 <= w_tag;
            r_tag2 <= r_tag1;
            if (w_any_gnt) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= w_cpu_gnt && cpu_we;
                r_mem_addr <= w_addr;
                r_mem_din  <= cpu_wdata;
            end else begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end
        end
    end

    // Stage 2 lines up with the RAM output of the tagged access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vga_rdata <= '0;
            r_vga_valid <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
        end else begin
            unique case (r_tag2.owner)
                OWNER_VGA: begin
                    r_vga_rdata <= mem_dout;
                    r_vga_valid <= 1'b1;
                    r_cpu_ack   <= 1'b0;
                end
                OWNER_CPU: begin
                    r_vga_valid <= 1'b0;
                    r_cpu_ack   <= 1'b1;
                    if (!r_tag2.we) begin
                        r_cpu_rdata <= mem_dout;
                    end
                end
                default: begin
                    r_vga_valid <= 1'b0;
                    r_cpu_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign vga_gnt   = w_vga_gnt;
    assign cpu_gnt   = w_cpu_gnt;
    assign vga_rdata = r_vga_rdata;
    assign vga_valid = r_vga_valid;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: RAM model, rule-level reference model with
// per-cycle comparison, directed scenarios and randomized requesters.
module tb_vga_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_gnt;
    logic [DW-1:0] vga_rdata;
    logic          vga_valid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;

    logic [DW-1:0] ram    [0:65535];
    logic [DW-1:0] shadow [0:65535];

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 0;

    always #10 clk = ~clk;

    vga_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_gnt   (vga_gnt),
        .vga_rdata (vga_rdata),
        .vga_valid (vga_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Write-first synchronous RAM
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_din;
                mem_dout      <= mem_din;
            end else begin
                mem_dout <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: grant rules, shadow memory at grant time,
    // responses due three negedges after the deciding negedge.
    typedef struct {
        int            due;
        bit            is_cpu;
        bit            we;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          q[$];
    int            ncyc   = 0;
    int            starve = 0;
    logic          e_en   = 0;
    logic          e_we   = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din  = '0;
    logic [DW-1:0] m_vrd  = '0;
    logic [DW-1:0] m_crd  = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit   ev;
            bit   ec;
            bit   gc;
            bit   gv;
            rsp_t r;
            ev = 0;
            ec = 0;
            if (q.size() > 0 && q[0].due == ncyc) begin
                r = q.pop_front();
                if (r.is_cpu) begin
                    ec = 1;
                    if (!r.we) m_crd = r.data;
                end else begin
                    ev = 1;
                    m_vrd = r.data;
                end
            end
            chk("m_vga_valid", 32'(vga_valid), 32'(ev));
            chk("m_cpu_ack", 32'(cpu_ack), 32'(ec));
            if (ev) chk("m_vga_rdata", 32'(vga_rdata), 32'(m_vrd));
            chk("m_cpu_rdata", 32'(cpu_rdata), 32'(m_crd));
            chk("m_mem_en", 32'(mem_en), 32'(e_en));
            chk("m_mem_we", 32'(mem_we), 32'(e_we));
            chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("m_mem_din", 32'(mem_din), 32'(e_din));
            if (rst) begin
                gc = 0;
                gv = 0;
            end else begin
                gc = cpu_req && (!vga_req || starve >= LIM);
                gv = vga_req && !gc;
            end
            chk("m_cpu_gnt", 32'(cpu_gnt), 32'(gc));
            chk("m_vga_gnt", 32'(vga_gnt), 32'(gv));
            if (rst) begin
                q.delete();
                starve = 0;
                e_en   = 0;
                e_we   = 0;
                e_addr = '0;
                e_din  = '0;
                m_vrd  = '0;
                m_crd  = '0;
            end else begin
                if (gc || gv) begin
                    e_en   = 1;
                    e_we   = gc && cpu_we;
                    e_addr = gc ? cpu_addr : vga_addr;
                    e_din  = cpu_wdata;
                    if (gc && cpu_we) shadow[cpu_addr] = cpu_wdata;
                    r.due    = ncyc + 3;
                    r.is_cpu = gc;
                    r.we     = gc && cpu_we;
                    r.data   = shadow[e_addr];
                    q.push_back(r);
                end else begin
                    e_en = 0;
                    e_we = 0;
                end
                if (cpu_req && !gc) starve = (starve < 255) ? starve + 1 : 255;
                else starve = 0;
            end
            ncyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vga_read(input logic [AW-1:0] a);
        bit g;
        int n;
        vga_req  = 1;
        vga_addr = a;
        g = 0;
        n = 0;
        while (!g && n < 400) begin
            @(negedge clk);
            g = vga_gnt;
            tick();
            n++;
        end
        if (!g) begin
            chk("vga_grant_timeout", 32'(g), 32'd1);
            vga_req = 0;
        end
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        bit g;
        int n;
        cpu_req   = 1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        g = 0;
        n = 0;
        while (!g && n < 400) begin
            @(negedge clk);
            g = cpu_gnt;
            tick();
            n++;
        end
        if (!g) begin
            chk("cpu_grant_timeout", 32'(g), 32'd1);
            cpu_req = 0;
        end
    endtask

    int             nval;
    int             nack;
    int             nwe;
    int             first_v;
    int             last_v;
    logic [DW-1:0]  vdat[$];
    logic [DW-1:0]  exp_d;
    int             n;
    bit             got;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]    = DW'(i + 16'h0100);
            shadow[i] = DW'(i + 16'h0100);
        end
        rst       = 1;
        vga_req   = 0;
        vga_addr  = '0;
        cpu_req   = 0;
        cpu_we    = 0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        tick();
        chk_en = 1;
        vga_req  = 1;
        cpu_req  = 1;
        vga_addr = 16'h0003;
        cpu_addr = 16'h0004;
        @(negedge clk);
        chk("rst_vga_gnt", 32'(vga_gnt), 32'd0);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_vga_valid", 32'(vga_valid), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        tick();
        rst     = 0;
        vga_req = 0;
        cpu_req = 0;
        repeat (2) tick();

        // VGA-only stream
        nval = 0; nack = 0; first_v = -1; last_v = -1;
        vdat.delete();
        fork
            begin
                for (int i = 1; i <= 5; i++) vga_read(AW'(i));
                vga_req = 0;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (vga_valid) begin
                        if (first_v < 0) first_v = i;
                        last_v = i;
                        nval++;
                        vdat.push_back(vga_rdata);
                    end
                    if (cpu_ack) nack++;
                end
            end
        join
        chk("s1_valid_count", 32'(nval), 32'd5);
        chk("s1_first_valid", 32'(first_v), 32'd3);
        chk("s1_last_valid", 32'(last_v), 32'd7);
        chk("s1_no_cpu_ack", 32'(nack), 32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_d = DW'(16'h0101 + i);
            if (i < vdat.size()) chk("s1_data", 32'(vdat[i]), 32'(exp_d));
        end
        repeat (3) tick();

        // CPU write then read-back
        nack = 0; nwe = 0;
        fork
            begin
                cpu_op(1'b1, 16'h0010, 16'h00AA);
                cpu_op(1'b0, 16'h0010, 16'h0000);
                cpu_req = 0;
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    if (mem_we) nwe++;
                    if (cpu_ack) begin
                        nack++;
                        if (nack == 1) chk("s2_wr_ack_cycle", 32'(i), 32'd3);
                        else begin
                            chk("s2_rd_ack_cycle", 32'(i), 32'd4);
                            chk("s2_rd_data", 32'(cpu_rdata), 32'h00AA);
                        end
                    end
                end
            end
        join
        chk("s2_mem_we_cycles", 32'(nwe), 32'd1);
        chk("s2_ack_count", 32'(nack), 32'd2);
        repeat (3) tick();

        // Simultaneous requests, counter at zero
        vga_req  = 1;
        vga_addr = 16'h0030;
        cpu_req  = 1;
        cpu_we   = 0;
        cpu_addr = 16'h0020;
        @(negedge clk);
        chk("s3_vga_first", 32'(vga_gnt), 32'd1);
        chk("s3_cpu_waits", 32'(cpu_gnt), 32'd0);
        tick();
        vga_req = 0;
        @(negedge clk);
        chk("s3_cpu_next", 32'(cpu_gnt), 32'd1);
        tick();
        cpu_req = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("s3_vga_valid", 32'(vga_valid), 32'd1);
        chk("s3_vga_data", 32'(vga_rdata), 32'h0130);
        chk("s3_cpu_not_yet", 32'(cpu_ack), 32'd0);
        tick();
        @(negedge clk);
        chk("s3_cpu_ack", 32'(cpu_ack), 32'd1);
        chk("s3_cpu_data", 32'(cpu_rdata), 32'h0120);
        repeat (3) tick();

        // Starvation guard, twice to show the counter restarts from zero
        vga_req  = 1;
        vga_addr = 16'h0040;
        for (int r = 0; r < 2; r++) begin
            cpu_req  = 1;
            cpu_we   = 0;
            cpu_addr = 16'h0041;
            n   = 0;
            got = 0;
            while (!got && n < 40) begin
                @(negedge clk);
                n++;
                if (cpu_gnt) begin
                    got = 1;
                    chk("s4_vga_loses", 32'(vga_gnt), 32'd0);
                end else if (n == 1) begin
                    chk("s4_vga_wins", 32'(vga_gnt), 32'd1);
                end
                tick();
            end
            cpu_req = 0;
            chk("s4_grant_cycle", 32'(n), 32'd9);
            @(negedge clk);
            chk("s4_vga_resumes", 32'(vga_gnt), 32'd1);
            tick();
        end
        vga_req = 0;
        repeat (4) tick();

        // Reset one clock after a VGA accept
        vga_read(16'h0005);
        vga_req = 0;
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("s5_mem_en", 32'(mem_en), 32'd0);
        chk("s5_mem_we", 32'(mem_we), 32'd0);
        chk("s5_mem_addr", 32'(mem_addr), 32'd0);
        chk("s5_mem_din", 32'(mem_din), 32'd0);
        chk("s5_vga_rdata", 32'(vga_rdata), 32'd0);
        chk("s5_cpu_rdata", 32'(cpu_rdata), 32'd0);
        nval = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            if (vga_valid) nval++;
        end
        chk("s5_no_valid", 32'(nval), 32'd0);
        tick();
        vga_read(16'h0007);
        vga_req = 0;
        @(negedge clk);
        chk("s5_lat_n1", 32'(vga_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("s5_lat_n2", 32'(vga_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("s5_lat_n3", 32'(vga_valid), 32'd1);
        chk("s5_data", 32'(vga_rdata), 32'h0107);
        repeat (3) tick();

        // Randomized traffic against the model
        fork
            begin
                bit hold;
                hold = 0;
                for (int i = 0; i < 200; i++) begin
                    if (!hold) repeat ($urandom_range(0, 2)) tick();
                    vga_read(AW'($urandom_range(0, 31)));
                    hold = ($urandom_range(0, 3) != 0);
                    if (!hold) vga_req = 0;
                end
                vga_req = 0;
            end
            begin
                bit hold;
                hold = 0;
                for (int i = 0; i < 120; i++) begin
                    if (!hold) repeat ($urandom_range(0, 3)) tick();
                    cpu_op(1'($urandom_range(0, 1)),
                           AW'($urandom_range(0, 31)),
                           DW'($urandom_range(0, 65535)));
                    hold = ($urandom_range(0, 1) != 0);
                    if (!hold) cpu_req = 0;
                end
                cpu_req = 0;
            end
        join
        repeat (6) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
